// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arbiter_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned SHAMT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // ALU_SLL shifts operand B left by A[4:0]
    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_SLL  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_AND  = 3'd4,
        ALU_SLTU = 3'd5,
        ALU_SLT  = 3'd6,
        ALU_XOR  = 3'd7
    } alu_op_e;

    typedef struct packed {
        alu_op_e           op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle for both ALU requesters.
interface alu_arbiter_if;
    import alu_arbiter_pkg::*;

    logic                req0_valid, req0_ready;
    logic [OP_W-1:0]     req0_op;
    logic [DATA_W-1:0]   req0_a, req0_b;
    logic                req1_valid, req1_ready;
    logic [OP_W-1:0]     req1_op;
    logic [DATA_W-1:0]   req1_a, req1_b;
    logic                rsp0_valid, rsp0_zero;
    logic [DATA_W-1:0]   rsp0_res;
    logic                rsp1_valid, rsp1_zero;
    logic [DATA_W-1:0]   rsp1_res;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_res, rsp0_zero,
        input  rsp1_valid, rsp1_res, rsp1_zero
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_res, rsp0_zero,
        output rsp1_valid, rsp1_res, rsp1_zero
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU shared by the arbiter.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res,
    output logic              zero
);

    always_comb begin
        res = '0;
        case (op)
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_SLL:  res = b << a[SHAMT_W-1:0];
            ALU_OR:   res = a | b;
            ALU_AND:  res = a & b;
            ALU_SLTU: res = DATA_W'(a < b);
            ALU_SLT:  res = DATA_W'($signed(a) < $signed(b));
            ALU_XOR:  res = a ^ b;
            default:  res = '0;
        endcase
        zero = (res == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU: IDLE -> EXEC -> RESP.
// Define ALU_ARB_RR_EN for round-robin; default is fixed priority with starvation relief.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
)
(
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus,
    output logic          busy
);

    state_e            state;
    req_t              req_q;
    logic              gnt_q;
    logic              sel;
    logic              accept;
    logic [DATA_W-1:0] alu_res;
    logic              alu_zero;

`ifdef ALU_ARB_RR_EN
    logic rr_ptr;
`else
    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));
`endif

    // Arbitration: a lone requester always wins; ties resolved by the scheme
    always_comb begin
        sel = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_RR_EN
            sel = rr_ptr;
`else
            sel = starved;
`endif
        end else if (bus.req1_valid) begin
            sel = 1'b1;
        end
    end

    assign bus.req0_ready = (state == IDLE) && !sel;
    assign bus.req1_ready = (state == IDLE) && sel;
    assign accept         = (state == IDLE) && (sel ? bus.req1_valid : bus.req0_valid);

    alu_arbiter_alu u_alu (
        .op   (req_q.op),
        .a    (req_q.a),
        .b    (req_q.b),
        .res  (alu_res),
        .zero (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            req_q          <= '0;
            gnt_q          <= 1'b0;
            busy           <= 1'b0;
            bus.rsp0_valid <= 1'b0;
            bus.rsp0_res   <= '0;
            bus.rsp0_zero  <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            bus.rsp1_res   <= '0;
            bus.rsp1_zero  <= 1'b0;
`ifdef ALU_ARB_RR_EN
            rr_ptr         <= 1'b0;
`else
            starve_cnt     <= '0;
`endif
        end else begin
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
`ifdef ALU_ARB_RR_EN
                    if (accept) rr_ptr <= !sel;
`else
                    // req1 valid and not selected implies req0 won a tie
                    if (!bus.req1_valid || sel) starve_cnt <= '0;
                    else if (!starved)          starve_cnt <= starve_cnt + CNT_W'(1);
`endif
                    if (accept) begin
                        req_q.op <= alu_op_e'(sel ? bus.req1_op : bus.req0_op);
                        req_q.a  <= sel ? bus.req1_a : bus.req0_a;
                        req_q.b  <= sel ? bus.req1_b : bus.req0_b;
                        gnt_q    <= sel;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (gnt_q) begin
                        bus.rsp1_valid <= 1'b1;
                        bus.rsp1_res   <= alu_res;
                        bus.rsp1_zero  <= alu_zero;
                    end else begin
                        bus.rsp0_valid <= 1'b1;
                        bus.rsp0_res   <= alu_res;
                        bus.rsp0_zero  <= alu_zero;
                    end
                    state <= RESP;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: random and directed traffic on both requesters.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int unsigned LIMIT = 4;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        int          due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy;

    alu_arbiter_if bus ();

    alu_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        q [2][$];
    logic [31:0] last_res  [2];
    logic        last_zero [2];

    // requester-side stimulus and reference arbitration state
    bit          pend [2];
    logic [2:0]  rop  [2];
    logic [31:0] ra   [2];
    logic [31:0] rb   [2];
    int          grants[$];
    int          busy_until = 0;
    int          losses     = 0;
    bit          ptr        = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return b << a[4:0];
            3'd3:    return a | b;
            3'd4:    return a & b;
            3'd5:    return (a < b) ? 32'd1 : 32'd0;
            3'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a ^ b;
        endcase
    endfunction

    task automatic drive();
        bus.req0_valid = pend[0]; bus.req0_op = rop[0]; bus.req0_a = ra[0]; bus.req0_b = rb[0];
        bus.req1_valid = pend[1]; bus.req1_op = rop[1]; bus.req1_a = ra[1]; bus.req1_b = rb[1];
    endtask

    // One IDLE/EXEC/RESP slot lasts 3 cycles; a tie goes to req1 after LIMIT straight losses
    task automatic model_cycle();
        bit   idle, v0, v1, s, acc;
        exp_t e;
        idle = (cyc >= busy_until);
        v0 = pend[0];
        v1 = pend[1];
        if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
            s = ptr;
`else
            s = (losses == int'(LIMIT));
`endif
        end else begin
            s = v1;
        end
        chk("busy", 32'(busy), 32'(!idle));
        chk("req0_ready", 32'(bus.req0_ready), 32'(idle && !s));
        chk("req1_ready", 32'(bus.req1_ready), 32'(idle && s));
        if (idle) begin
            acc = s ? v1 : v0;
`ifdef ALU_ARB_RR_EN
            if (acc) ptr = !s;
`else
            if (v0 && v1 && !s) begin
                if (losses < int'(LIMIT)) losses++;
            end else begin
                losses = 0;
            end
`endif
            if (acc) begin
                e.res  = ref_alu(rop[s], ra[s], rb[s]);
                e.zero = (e.res == 32'd0);
                e.due  = cyc + 2;
                q[s].push_back(e);
                grants.push_back(int'(s));
                busy_until = cyc + 3;
                pend[s]    = 1'b0;
            end
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        if (rst_n) model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int n, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        pend[n] = 1'b1; rop[n] = op; ra[n] = a; rb[n] = b;
    endtask

    task automatic rand_req(input int n);
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 3))
            0: a = 32'hFFFF_FFFF;
            1: b = a;
            2: b = 32'($urandom_range(0, 40));
            default: ;
        endcase
        issue(n, 3'($urandom_range(0, 7)), a, b);
    endtask

    task automatic wait_accept(input int max);
        int k = 0;
        while ((pend[0] || pend[1]) && k < max) begin
            step();
            k++;
        end
        chk("accept timeout", {30'd0, pend[1], pend[0]}, 32'd0);
    endtask

    task automatic go(input int max);
        wait_accept(max);
        repeat (3) step();
    endtask

    task automatic reset_model();
        busy_until = cyc;
        losses     = 0;
        ptr        = 1'b0;
    endtask

    task automatic mon(input int n);
        logic        v, z;
        logic [31:0] r;
        bit          exp_v;
        exp_t        e;
        v = n ? bus.rsp1_valid : bus.rsp0_valid;
        r = n ? bus.rsp1_res   : bus.rsp0_res;
        z = n ? bus.rsp1_zero  : bus.rsp0_zero;
        exp_v = (q[n].size() > 0) && (q[n][0].due == cyc);
        chk($sformatf("rsp%0d_valid", n), 32'(v), 32'(exp_v));
        if (exp_v) begin
            e = q[n].pop_front();
            last_res[n]  = e.res;
            last_zero[n] = e.zero;
        end
        chk($sformatf("rsp%0d_res", n), r, last_res[n]);
        chk($sformatf("rsp%0d_zero", n), 32'(z), 32'(last_zero[n]));
        if (q[n].size() > 0 && q[n][0].due < cyc) void'(q[n].pop_front());
    endtask

    // Monitor: compares DUT responses against the scoreboard every cycle
    initial begin
        last_res  = '{32'd0, 32'd0};
        last_zero = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
                chk("reset rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
                chk("reset rsp0_res", bus.rsp0_res, 32'd0);
                chk("reset rsp1_res", bus.rsp1_res, 32'd0);
                chk("reset zeros", {30'd0, bus.rsp1_zero, bus.rsp0_zero}, 32'd0);
                chk("reset busy", 32'(busy), 32'd0);
                last_res  = '{32'd0, 32'd0};
                last_zero = '{1'b0, 1'b0};
            end else begin
                mon(0);
                mon(1);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int          g0;
    logic [31:0] exp_order;
    int          n_order;

    initial begin
        pend = '{1'b0, 1'b0};
        rop  = '{3'd0, 3'd0};
        ra   = '{32'd0, 32'd0};
        rb   = '{32'd0, 32'd0};
        rst_n = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_model();

        // lone requests
        issue(0, 3'd0, 32'd5, 32'd3);           go(20);
        issue(1, 3'd2, 32'd4, 32'd1);           go(20);
        issue(0, 3'd0, 32'hFFFF_FFFF, 32'd1);   go(20);
        issue(1, 3'd7, 32'h1234, 32'h1234);     go(20);

        // both requesters held valid back to back
`ifdef ALU_ARB_RR_EN
        exp_order = 32'b1010;
        n_order   = 4;
`else
        exp_order = 32'b10000_10000;
        n_order   = 10;
`endif
        g0 = grants.size();
        for (int k = 0; k < 200 && (grants.size() - g0) < n_order; k++) begin
            if (!pend[0]) rand_req(0);
            if (!pend[1]) rand_req(1);
            step();
        end
        chk("grant count", 32'(grants.size() - g0 >= n_order), 32'd1);
        for (int i = 0; i < n_order; i++) begin
            if (g0 + i < grants.size())
                chk($sformatf("grant[%0d]", i), 32'(grants[g0 + i]), 32'(exp_order[i]));
        end
        go(20);

        // operand change during EXEC must not leak into the result
        issue(0, 3'd0, 32'd5, 32'd3);
        wait_accept(20);
        ra[0] = 32'd9;
        repeat (3) step();

        // reset in the middle of an operation drops it
        issue(0, 3'd1, 32'd7, 32'd7);
        wait_accept(20);
        rst_n = 1'b0;
        q[0].delete();
        q[1].delete();
        pend = '{1'b0, 1'b0};
        repeat (3) step();
        rst_n = 1'b1;
        reset_model();
        repeat (2) step();
        issue(0, 3'd0, 32'd1, 32'd2);           go(20);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            for (int n = 0; n < 2; n++)
                if (!pend[n] && $urandom_range(0, 2) == 0) rand_req(n);
            step();
        end
        go(40);

        chk("scoreboard empty", 32'(q[0].size() + q[1].size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
